// File: rtl/adc_frame_scan.sv
// Scans CH_NUM tactile channels: mux select, settle, paired ADC conversion, sign-magnitude record out.
// Latency per channel (ready high): SETTLE_CYC + Tc + 2 cycles; record appears the cycle after both results land.
// Backpressure: record held with data_vld_o high until data_rdy_i; scanning stalls in PRESENT meanwhile.
// Optional: define ADC_AVG_EN to average 4 conversions per channel before conversion to sign-magnitude.
module adc_frame_scan #(
    parameter int CH_NUM      = 16,
    parameter int SETTLE_CYC  = 500,
    parameter int TIMEOUT_CYC = 4095
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        scan_en_i,
    output logic [3:0]  mux_sel_o,
    output logic        mem_adc_start_o,
    input  logic        mem_adc_done_i,
    input  logic [15:0] mem_adc_data_i,
    output logic        piezo_adc_start_o,
    input  logic        piezo_adc_done_i,
    input  logic [15:0] piezo_adc_data_i,
    output logic [15:0] memristor_adc_data_o,
    output logic [15:0] piezo_adc_data_o,
    output logic [3:0]  ch_sign_o,
    output logic        data_vld_o,
    input  logic        data_rdy_i,
    output logic        frame_done_o,
    output logic        adc_timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CONVERT = 2'd2,
        S_PRESENT = 2'd3
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  CH_LAST     = 4'(CH_NUM - 1);

    // Raw two's complement to sign-magnitude, bit15 set = positive.
    // The most negative code has no positive twin in 15 bits, so it saturates.
    function automatic logic [15:0] to_sm(input logic [15:0] r);
        logic [15:0] neg;
        neg = 16'd0 - r;
        if (!r[15])
            return {1'b1, r[14:0]};
        else if (r == 16'h8000)
            return 16'h7FFF;
        else
            return {1'b0, neg[14:0]};
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cyc_cnt_q, cyc_cnt_d;      // settle count in SETTLE, timeout count in CONVERT
    logic [3:0]  ch_cnt_q;
    logic        start_q, start_d;
    logic        mem_got_q, pz_got_q;
    logic [15:0] mem_cap_q, pz_cap_q;
    logic [15:0] mem_out_q, pz_out_q;
    logic [3:0]  ch_sign_q;
    logic        tmo_q;

    logic [15:0] mem_sample, pz_sample;    // this conversion's result, live done input wins
    logic [15:0] mem_final, pz_final;      // value that goes out through sign-magnitude
    logic        both_now;
    logic        tmo_hit;
    logic        sample_end;
    logic        last_sample;
    logic        present_load;
    logic        xfer;

    // A missing result (timeout) contributes raw zero.
    assign mem_sample = mem_adc_done_i   ? mem_adc_data_i   : (mem_got_q ? mem_cap_q : 16'h0000);
    assign pz_sample  = piezo_adc_done_i ? piezo_adc_data_i : (pz_got_q  ? pz_cap_q  : 16'h0000);
    assign both_now   = (mem_got_q | mem_adc_done_i) & (pz_got_q | piezo_adc_done_i);
    assign tmo_hit    = (cyc_cnt_q == TMO_LAST);
    assign sample_end = (state_q == S_CONVERT) && (both_now || tmo_hit);
    assign xfer       = (state_q == S_PRESENT) && data_rdy_i;

`ifdef ADC_AVG_EN
    logic [1:0]  samp_q;
    logic [17:0] mem_acc_q, pz_acc_q;
    logic [17:0] mem_sum, pz_sum;

    assign mem_sum     = mem_acc_q + {{2{mem_sample[15]}}, mem_sample};
    assign pz_sum      = pz_acc_q  + {{2{pz_sample[15]}},  pz_sample};
    assign last_sample = (samp_q == 2'd3);
    // Arithmetic shift by 2 of the 18-bit sum: dropping the low bits floors toward -inf.
    assign mem_final   = mem_sum[17:2];
    assign pz_final    = pz_sum[17:2];

    // Accumulate four samples per channel; clear once the channel's average is taken.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            samp_q    <= 2'd0;
            mem_acc_q <= 18'd0;
            pz_acc_q  <= 18'd0;
        end else if (sample_end) begin
            if (last_sample) begin
                samp_q    <= 2'd0;
                mem_acc_q <= 18'd0;
                pz_acc_q  <= 18'd0;
            end else begin
                samp_q    <= samp_q + 2'd1;
                mem_acc_q <= mem_sum;
                pz_acc_q  <= pz_sum;
            end
        end
    end
`else
    assign last_sample = 1'b1;
    assign mem_final   = mem_sample;
    assign pz_final    = pz_sample;
`endif

    // Next-state, start pulse request and shared cycle counter.
    always_comb begin
        state_d      = state_q;
        start_d      = 1'b0;
        cyc_cnt_d    = cyc_cnt_q + 16'd1;
        present_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                cyc_cnt_d = 16'd0;
                if (scan_en_i)
                    state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cyc_cnt_q == SETTLE_LAST) begin
                    state_d   = S_CONVERT;
                    start_d   = 1'b1;
                    cyc_cnt_d = 16'd0;
                end
            end
            S_CONVERT: begin
                if (sample_end) begin
                    cyc_cnt_d = 16'd0;
                    if (last_sample) begin
                        state_d      = S_PRESENT;
                        present_load = 1'b1;
                    end else begin
                        // Another conversion round for averaging, no re-settle.
                        start_d = 1'b1;
                    end
                end
            end
            S_PRESENT: begin
                cyc_cnt_d = 16'd0;
                if (xfer)
                    state_d = scan_en_i ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                cyc_cnt_d = 16'd0;
            end
        endcase
    end

    // State, counter and start pulse registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cyc_cnt_q <= 16'd0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_cnt_q <= cyc_cnt_d;
            start_q   <= start_d;
        end
    end

    // Capture each ADC result on its own done pulse; only meaningful while converting.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_got_q <= 1'b0;
            pz_got_q  <= 1'b0;
            mem_cap_q <= 16'h0000;
            pz_cap_q  <= 16'h0000;
        end else if (state_q == S_CONVERT) begin
            if (sample_end) begin
                mem_got_q <= 1'b0;
                pz_got_q  <= 1'b0;
            end else begin
                if (mem_adc_done_i) begin
                    mem_got_q <= 1'b1;
                    mem_cap_q <= mem_adc_data_i;
                end
                if (piezo_adc_done_i) begin
                    pz_got_q <= 1'b1;
                    pz_cap_q <= piezo_adc_data_i;
                end
            end
        end
    end

    // Record registers load only on entry to PRESENT; downstream reads them long after the handshake.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mem_out_q <= 16'h0000;
            pz_out_q  <= 16'h0000;
            ch_sign_q <= 4'd0;
        end else if (present_load) begin
            mem_out_q <= to_sm(mem_final);
            pz_out_q  <= to_sm(pz_final);
            ch_sign_q <= ch_cnt_q;
        end
    end

    // Channel counter advances on each transfer and drives the mux directly.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            ch_cnt_q <= 4'd0;
        else if (xfer)
            ch_cnt_q <= (ch_cnt_q == CH_LAST) ? 4'd0 : ch_cnt_q + 4'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            tmo_q <= 1'b0;
        else if (sample_end && !both_now)
            tmo_q <= 1'b1;
    end

    assign mux_sel_o            = ch_cnt_q;
    assign mem_adc_start_o      = start_q;
    assign piezo_adc_start_o    = start_q;
    assign memristor_adc_data_o = mem_out_q;
    assign piezo_adc_data_o     = pz_out_q;
    assign ch_sign_o            = ch_sign_q;
    assign data_vld_o           = (state_q == S_PRESENT);
    assign frame_done_o         = xfer && (ch_cnt_q == CH_LAST);
    assign adc_timeout_o        = tmo_q;

endmodule
